rng_sample_arbiter: RTL
=======================

Name: rng_sample_arbiter

Overview:
- Sits between the non-uniform rng core and its consumers.
- Discards the core's start-up garbage, then buffers valid samples in a small FIFO.
- Shares the buffered samples among N_REQ requesters using round-robin arbitration with a req/ack handshake.
- Throttles the generator through gen_ready when the buffer is full.

Parameters:
- BY, 16: sample width; matches the rng core output width.
- N_REQ, 4: number of requesters; range 2..8.
- DEPTH, 8: FIFO depth in samples; power of 2, at least 2.
- WARMUP, 4: number of accepted generator samples discarded after reset or flush; at least 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the FIFO; restarts warm-up.
- gen_sample  in  BY  sample from the rng core.
- gen_valid  in  1  gen_sample is valid this cycle.
- gen_ready  out  1  block accepts gen_sample this cycle.
- req  in  N_REQ  per-requester request level.
- ack  out  N_REQ  one-hot, one-cycle pulse; data is valid for the acked requester.
- data  out  BY  delivered sample.
- grant_id  out  clog2(N_REQ)  index of the last acked requester.
- fill  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow_err  out  1  sticky flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=WARMUP, warm-up counter=0, FIFO empty, fill=0.
  - ack=0, data=0, grant_id=0, overflow_err=0.
  - Round-robin pointer set so that requester 0 has highest priority.
- gen_ready is combinational:
  - WARMUP: gen_ready=1.
  - RUN: gen_ready = (fill != DEPTH), evaluated on pre-pop occupancy. A pop in the same cycle does not make room.
  - FLUSH: gen_ready=0.
- Accept = gen_valid & gen_ready.
- State machine:
  - WARMUP: each accept increments the counter and the sample is dropped. On the accept that brings the count to WARMUP, go to RUN (that sample is also dropped). No acks are issued.
  - RUN: each accept writes gen_sample at the write pointer. Pointers wrap modulo DEPTH. fill increments.
  - FLUSH: lasts exactly one cycle. FIFO is emptied (pointers=0, fill=0), warm-up counter cleared, next state WARMUP.
  - flush=1 in any state moves to FLUSH on the next edge. It overrides any push or pop in that cycle, and ack=0 in the following cycle.
- Arbitration (RUN only; condition: fill != 0 and req != 0, using pre-push fill):
  - Select the first requester with req=1, scanning from (last grant + 1) mod N_REQ upward with wrap.
  - Next edge:
    - ack[sel]=1
    - data = FIFO head
    - grant_id = sel
    - read pointer advances, fill decrements
    - pointer := sel
  - Otherwise at the next edge: ack=0; data and grant_id hold.
  - Latency: 1 cycle from arbitration condition true to ack.
- Push and pop in the same cycle:
  - fill is unchanged; both pointers advance.
  - When fill=0, a same-cycle push cannot be popped; the earliest ack is the following cycle.
- Requester rules:
  - req held high during the ack cycle counts as a new request.
  - Round-robin still gives the other active requesters priority first.
  - Dropping req before ack withdraws the request; no sample is lost.
- Throughput: at most one sample delivered and one accepted per cycle.
- overflow_err:
  - Set when gen_valid=1 while state=RUN and fill=DEPTH. This flags a generator that ignores gen_ready.
  - The sample is dropped.
  - Cleared only by rst_n; flush does not clear it.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Test Plan:
- Reset, WARMUP=4, gen_valid held high with samples 0x0001..0x0006, req=4'b0001 → samples 1..4 dropped. First ack=4'b0001 arrives with data=0x0005, one cycle after that sample is written; second ack delivers data=0x0006. fill returns to 0.
- RUN with FIFO pre-filled with 0x10..0x17 (DEPTH=8), req=4'b1111 held → acks 0001, 0010, 0100, 1000, 0001, ... on consecutive cycles; data=0x10, 0x11, ...; grant_id=0, 1, 2, 3, 0.
- FIFO full (fill=8), gen_valid=1, one pop that cycle → gen_ready=0 for that cycle and nothing is written; the next cycle gen_ready=1 and the write is accepted. A generator that ignores gen_ready while full → overflow_err=1 and stays 1 through a following flush.
- fill=3, flush=1 asserted together with gen_valid and req → no ack next cycle, fill=0. Then WARMUP discards 4 samples, and only the 5th new sample reaches a requester.
- Pointer wrap: stream 20 samples 0x20..0x33 through DEPTH=8 while req=4'b0100 is held → ack[2] fires 20 times with data in exact order 0x20..0x33; grant_id=2 every time.
- rst_n pulsed low mid-stream for less than one clock period → ack, data, fill and overflow_err drop to 0 without waiting for clk; state returns to WARMUP.

Source files
------------

// File: rtl/rng_sample_arbiter_if.sv
// Sample-delivery bus between the rng sample arbiter and its generator/consumers.
// The slave modport is the arbiter; the master modport is the surrounding logic.
interface rng_sample_arbiter_if #(
    parameter int BY    = 16,
    parameter int N_REQ = 4,
    parameter int DEPTH = 8
);
    localparam int IDW = $clog2(N_REQ);
    localparam int FW  = $clog2(DEPTH) + 1;

    logic               flush;
    logic [BY-1:0]      gen_sample;
    logic               gen_valid;
    logic               gen_ready;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   ack;
    logic [BY-1:0]      data;
    logic [IDW-1:0]     grant_id;
    logic [FW-1:0]      fill;
    logic               overflow_err;

    modport master (
        output flush, gen_sample, gen_valid, req,
        input  gen_ready, ack, data, grant_id, fill, overflow_err
    );

    modport slave (
        input  flush, gen_sample, gen_valid, req,
        output gen_ready, ack, data, grant_id, fill, overflow_err
    );
endinterface

// File: rtl/rng_sample_arbiter.sv
// Drops rng warm-up samples, buffers the rest and deals them round-robin to N_REQ requesters.
// Latency: 1 cycle from (fill != 0 and req != 0) to ack; a sample pushed into an empty FIFO is ackable one cycle later.
// Backpressure: gen_ready falls while the FIFO is full (pre-pop) or flushing; samples sent anyway set overflow_err.
module rng_sample_arbiter #(
    parameter int BY     = 16,
    parameter int N_REQ  = 4,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rng_sample_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int CW  = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      warm_cnt;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [FW-1:0]      fill_q;
    logic [N_REQ-1:0]   ack_q;
    logic [BY-1:0]      data_q;
    logic [IDW-1:0]     grant_q;
    logic [IDW-1:0]     rr_ptr;
    logic               ovf_q;
    logic [BY-1:0]      mem [DEPTH];

    logic               gen_ready;
    logic               accept;
    logic               push;
    logic               pop;
    logic               found;
    logic [IDW-1:0]     sel;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int k;
        k = int'(base) + off;
        if (k >= N_REQ) k = k - N_REQ;
        return IDW'(k);
    endfunction

    // Full is judged on pre-pop occupancy so a pop never opens a same-cycle slot.
    assign gen_ready = (state == ST_WARMUP) ||
                       ((state == ST_RUN) && (fill_q != FW'(DEPTH)));
    assign accept    = bus.gen_valid && gen_ready;
    assign push      = accept && (state == ST_RUN) && !bus.flush;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && bus.req[rr_idx(rr_ptr, i)]) begin
                sel   = rr_idx(rr_ptr, i);
                found = 1'b1;
            end
        end
    end

    assign pop = (state == ST_RUN) && !bus.flush && (fill_q != '0) && found;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.gen_sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WARMUP;
            warm_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_q   <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            grant_q  <= '0;
            rr_ptr   <= IDW'(N_REQ - 1);
            ovf_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            if (bus.gen_valid && (state == ST_RUN) && (fill_q == FW'(DEPTH))) begin
                ovf_q <= 1'b1;
            end
            // Flush wins over any push/pop and empties the FIFO at this very edge.
            if (bus.flush) begin
                state    <= ST_FLUSH;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fill_q   <= '0;
                warm_cnt <= '0;
            end else begin
                case (state)
                    ST_WARMUP: begin
                        if (accept) begin
                            warm_cnt <= warm_cnt + CW'(1);
                            if (warm_cnt == CW'(WARMUP - 1)) state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (push) wr_ptr <= wr_ptr + AW'(1);
                        if (pop) begin
                            rd_ptr  <= rd_ptr + AW'(1);
                            ack_q   <= N_REQ'(1) << sel;
                            data_q  <= mem[rd_ptr];
                            grant_q <= sel;
                            rr_ptr  <= sel;
                        end
                        if (push && !pop)      fill_q <= fill_q + FW'(1);
                        else if (pop && !push) fill_q <= fill_q - FW'(1);
                    end
                    ST_FLUSH: begin
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        fill_q   <= '0;
                        warm_cnt <= '0;
                        state    <= ST_WARMUP;
                    end
                    default: state <= ST_WARMUP;
                endcase
            end
        end
    end

    assign bus.gen_ready    = gen_ready;
    assign bus.ack          = ack_q;
    assign bus.data         = data_q;
    assign bus.grant_id     = grant_q;
    assign bus.fill         = fill_q;
    assign bus.overflow_err = ovf_q;
endmodule
